mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory port between three requesters: data load/store (R0), instruction
//  fetch (R1) and external DMA (R2). One outstanding transaction at a time. Fixed priority
//  R0>R1>R2 with starvation promotion for R1/R2. Sits between pipeline/DMA and memory interface.
// PARAMETERS
//  ADDR_W          32   address width
//  DATA_W          32   data width
//  STARVE_LIMIT    8    cycles R1/R2 may wait (req high, not granted) before promotion; >=1
//  TIMEOUT_CYCLES  64   BUSY cycles before abort (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk        in   1        clock
//  rst_n      in   1        async active-low reset
//  rN_req     in   1        request, N=0..2; held with addr/we/wdata stable until rN_gnt
//  rN_we      in   1        1=write, 0=read
//  rN_addr    in   ADDR_W   address
//  rN_wdata   in   DATA_W   write data
//  rN_gnt     out  1        1-cycle pulse: request accepted
//  rN_rvalid  out  1        1-cycle pulse: transaction complete (read or write)
//  rN_err     out  1        with rN_rvalid: transaction aborted by timeout
//  rdata      out  DATA_W   shared read data, valid with any rN_rvalid
//  mem_req    out  1        memory request, held high through BUSY
//  mem_we     out  1        registered write enable
//  mem_addr   out  ADDR_W   registered address
//  mem_wdata  out  DATA_W   registered write data
//  mem_ready  in   1        memory completion; sampled only in BUSY
//  mem_rdata  in   DATA_W   memory read data, valid with mem_ready
//  busy       out  1        1 while state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE; all gnt/rvalid/err/mem_req/mem_we/busy = 0; mem_addr/mem_wdata/rdata = 0;
//    starvation counters = 0. Reset mid-transaction drops it: no rvalid issued; owner must re-request.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//    IDLE: if any req, winner's gnt pulses this cycle; addr/we/wdata/owner captured at clock edge -> BUSY.
//    BUSY: mem_req=1 with captured fields; mem_ready=1 -> capture mem_rdata into rdata -> DONE.
//    DONE: owner's rvalid=1 (err=0) for one cycle; mem_req=0 -> IDLE.
//  - Latency: gnt at cycle T, mem_req T+1..T+k, mem_ready at T+k, rvalid at T+k+1.
//    Minimum 3 cycles/transaction; no back-to-back grant from DONE.
//  - Arbitration (IDLE only, combinational on req): promoted requester first (R1 before R2 if
//    both promoted), else R0>R1>R2. Promoted = wait counter == STARVE_LIMIT.
//  - Wait counter (R1, R2): +1 per cycle req=1 and not granted (any state), saturates at
//    STARVE_LIMIT; cleared on own gnt or req=0.
//  - rdata holds last value until next capture; undefined meaning after writes (mem_rdata copied).
//  - mem_ready outside BUSY is ignored. A requester's req during its own BUSY/DONE is not granted
//    until IDLE.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: BUSY cycle counter; after TIMEOUT_CYCLES in BUSY without mem_ready,
//    go to DONE, rdata=0, owner rvalid=1 and err=1. mem_ready on the same cycle the limit
//    is reached wins (normal completion).
//  MEM_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; all rN_err tied 0.
// TESTING
//  1 R1 read addr 0x100; mem_ready 2 cycles after mem_req, mem_rdata=0xDEADBEEF
//    -> r1_gnt T, mem_req T+1..T+2, r1_rvalid T+3, rdata=0xDEADBEEF.
//  2 R0,R1,R2 req same cycle -> grant order R0,R1,R2; each gnt only in IDLE, 3+ cycles apart.
//  3 R0 re-requests continuously, R1 held; STARVE_LIMIT=8
//    -> R1 granted at first IDLE after 8 wait cycles, ahead of R0.
//  4 R0 write 0x55AA to 0x40 -> mem_we=1, mem_addr=0x40, mem_wdata=0x55AA held until mem_ready;
//    r0_rvalid next cycle.
//  5 rst_n low during BUSY -> mem_req=0, busy=0, no rvalid; after release R2 req granted normally.
//  6 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready never -> owner rvalid=1, err=1, rdata=0 after
//    4 BUSY cycles; IDLE next.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Three-requester memory port arbiter (R0 load/store, R1 fetch, R2 DMA), one transaction in flight.
// Optional BUSY timeout abort is compiled in with `define MEM_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int STARVE_LIMIT   = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_r0_req,
    input  logic              i_r0_we,
    input  logic [ADDR_W-1:0] i_r0_addr,
    input  logic [DATA_W-1:0] i_r0_wdata,
    output logic              o_r0_gnt,
    output logic              o_r0_rvalid,
    output logic              o_r0_err,

    input  logic              i_r1_req,
    input  logic              i_r1_we,
    input  logic [ADDR_W-1:0] i_r1_addr,
    input  logic [DATA_W-1:0] i_r1_wdata,
    output logic              o_r1_gnt,
    output logic              o_r1_rvalid,
    output logic              o_r1_err,

    input  logic              i_r2_req,
    input  logic              i_r2_we,
    input  logic [ADDR_W-1:0] i_r2_addr,
    input  logic [DATA_W-1:0] i_r2_wdata,
    output logic              o_r2_gnt,
    output logic              o_r2_rvalid,
    output logic              o_r2_err,

    output logic [DATA_W-1:0] o_rdata,

    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic [DATA_W-1:0] i_mem_rdata,

    output logic              o_busy,
    output logic [1:0]        o_state
);

    // Handshake: a requester holds req with stable we/addr/wdata until its gnt pulse (the cycle
    // the fields are captured); rvalid pulses once when its transaction ends, err alongside it.
    // On the memory side mem_req stays high with stable fields until mem_ready is seen in BUSY.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_owner;
    logic [WAIT_W-1:0]   r_wait1;
    logic [WAIT_W-1:0]   r_wait2;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_mem_we;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_idle;
    logic                w_prom1;
    logic                w_prom2;
    logic [2:0]          w_gnt;
    logic [1:0]          w_sel_id;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_timeout;
    logic                w_done0;
    logic                w_done1;
    logic                w_done2;

    assign w_idle  = (r_state == S_IDLE);
    // A counter left at the limit from a previous cycle must not promote a dropped request.
    assign w_prom1 = i_r1_req && (r_wait1 == WAIT_W'(STARVE_LIMIT));
    assign w_prom2 = i_r2_req && (r_wait2 == WAIT_W'(STARVE_LIMIT));

    always_comb begin
        w_gnt = 3'b000;
        if (w_idle) begin
            if (w_prom1)       w_gnt = 3'b010;
            else if (w_prom2)  w_gnt = 3'b100;
            else if (i_r0_req) w_gnt = 3'b001;
            else if (i_r1_req) w_gnt = 3'b010;
            else if (i_r2_req) w_gnt = 3'b100;
        end
    end

    always_comb begin
        w_sel_id    = 2'd0;
        w_sel_we    = i_r0_we;
        w_sel_addr  = i_r0_addr;
        w_sel_wdata = i_r0_wdata;
        if (w_gnt[1]) begin
            w_sel_id    = 2'd1;
            w_sel_we    = i_r1_we;
            w_sel_addr  = i_r1_addr;
            w_sel_wdata = i_r1_wdata;
        end else if (w_gnt[2]) begin
            w_sel_id    = 2'd2;
            w_sel_we    = i_r2_we;
            w_sel_addr  = i_r2_addr;
            w_sel_wdata = i_r2_wdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (|w_gnt) w_state_nxt = S_BUSY;
            S_BUSY:  if (i_mem_ready || w_timeout) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= 2'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_idle && (|w_gnt)) begin
            r_owner     <= w_sel_id;
            r_mem_we    <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
        end
    end

    // Normal completion takes precedence over a timeout landing on the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (r_state == S_BUSY) begin
            if (i_mem_ready)    r_rdata <= i_mem_rdata;
            else if (w_timeout) r_rdata <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait1 <= '0;
            r_wait2 <= '0;
        end else begin
            if (!i_r1_req || w_gnt[1])                r_wait1 <= '0;
            else if (r_wait1 != WAIT_W'(STARVE_LIMIT)) r_wait1 <= r_wait1 + WAIT_W'(1);
            if (!i_r2_req || w_gnt[2])                r_wait2 <= '0;
            else if (r_wait2 != WAIT_W'(STARVE_LIMIT)) r_wait2 <= r_wait2 + WAIT_W'(1);
        end
    end

    assign w_done0 = (r_state == S_DONE) && (r_owner == 2'd0);
    assign w_done1 = (r_state == S_DONE) && (r_owner == 2'd1);
    assign w_done2 = (r_state == S_DONE) && (r_owner == 2'd2);

`ifdef MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    // r_to_cnt counts completed BUSY cycles; the limit fires in the last allowed BUSY cycle.
    assign w_timeout = (r_state == S_BUSY) && !i_mem_ready &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_to_cnt <= '0;
        else if (r_state != S_BUSY) r_to_cnt <= '0;
        else if (!w_timeout)        r_to_cnt <= r_to_cnt + TO_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   r_err <= 1'b0;
        else if (w_idle && (|w_gnt))  r_err <= 1'b0;
        else if (r_state == S_BUSY)   r_err <= w_timeout;
    end

    assign o_r0_err = w_done0 && r_err;
    assign o_r1_err = w_done1 && r_err;
    assign o_r2_err = w_done2 && r_err;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign o_r0_err         = 1'b0;
    assign o_r1_err         = 1'b0;
    assign o_r2_err         = 1'b0;
`endif

    assign o_r0_gnt    = w_gnt[0];
    assign o_r1_gnt    = w_gnt[1];
    assign o_r2_gnt    = w_gnt[2];
    assign o_r0_rvalid = w_done0;
    assign o_r1_rvalid = w_done1;
    assign o_r2_rvalid = w_done2;
    assign o_rdata     = r_rdata;
    assign o_mem_req   = (r_state == S_BUSY);
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = (r_state != S_IDLE);
    assign o_state     = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests with hand-computed grant order,
// memory fields, read data, error flag and latency; a behavioural memory answers mem_req.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic [1:0]  id;
        logic        err;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [7:0]  lat;    // cycles from gnt to rvalid
        logic [7:0]  mreq;   // cycles mem_req is high
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req [3];
    logic        we [3];
    logic [31:0] addr [3];
    logic [31:0] wdata [3];
    logic        gnt [3];
    logic        rvalid [3];
    logic        err [3];
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;
    logic [1:0]  state;

    txn_t        exp_q[$];
    logic [1:0]  exp_gnt_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    logic [31:0] rd_key = 32'h0;
    bit          stray_en = 1'b0;
    int          busy_cnt = 0;
    int          gnt_cyc = 0;
    int          mreq_cnt = 0;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(8), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_r0_req(req[0]), .i_r0_we(we[0]), .i_r0_addr(addr[0]), .i_r0_wdata(wdata[0]),
        .o_r0_gnt(gnt[0]), .o_r0_rvalid(rvalid[0]), .o_r0_err(err[0]),
        .i_r1_req(req[1]), .i_r1_we(we[1]), .i_r1_addr(addr[1]), .i_r1_wdata(wdata[1]),
        .o_r1_gnt(gnt[1]), .o_r1_rvalid(rvalid[1]), .o_r1_err(err[1]),
        .i_r2_req(req[2]), .i_r2_we(we[2]), .i_r2_addr(addr[2]), .i_r2_wdata(wdata[2]),
        .o_r2_gnt(gnt[2]), .o_r2_rvalid(rvalid[2]), .o_r2_err(err[2]),
        .o_rdata(rdata),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
        .o_busy(busy), .o_state(state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory model ----------------
    // Ready in the mem_lat-th BUSY cycle (0 = never); rdata = addr ^ rd_key. With stray_en,
    // ready is also pulsed outside BUSY carrying junk data that must be ignored.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                busy_cnt++;
                mem_ready = (mem_lat != 0) && (busy_cnt == mem_lat);
            end else begin
                busy_cnt  = 0;
                mem_ready = stray_en;
            end
            mem_rdata = (mem_req && mem_ready) ? (mem_addr ^ rd_key) : 32'h0BAD_0BAD;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int id, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        req[id]   = r;
        we[id]    = w;
        addr[id]  = a;
        wdata[id] = d;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the grant.
    task automatic issue(input int id, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input bit keep);
        bit got;
        got = 1'b0;
        set_req(id, 1'b1, w, a, d);
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            got = gnt[id];
        end
        if (!got) check($sformatf("gnt_wait_r%0d", id), 64'(got), 64'd1);
        @(posedge clk);
        #1;
        if (!keep) set_req(id, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_bound", 64'(n < 300), 64'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic txn_t mk(input logic [1:0] id, input logic e, input logic w,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] rd, input int lat, input int mreq);
        txn_t t;
        t.id = id; t.err = e; t.we = w; t.addr = a; t.wdata = d; t.rdata = rd;
        t.lat = 8'(lat); t.mreq = 8'(mreq);
        return t;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int         mon_ng;
    logic [1:0] mon_id;
    logic [1:0] mon_g;
    txn_t       mon_e;

    always @(negedge clk) begin
        if (rst_n) begin
            mon_ng = int'(gnt[0]) + int'(gnt[1]) + int'(gnt[2]);
            if (mon_ng != 0) begin
                mon_id = gnt[2] ? 2'd2 : (gnt[1] ? 2'd1 : 2'd0);
                check("gnt_onehot", 64'(mon_ng), 64'd1);
                check("gnt_only_idle", 64'(busy), 64'd0);
                if (exp_gnt_q.size() == 0) begin
                    check("gnt_unexpected", 64'(mon_ng), 64'd0);
                end else begin
                    mon_g = exp_gnt_q.pop_front();
                    check("gnt_id", 64'(mon_id), 64'(mon_g));
                end
                gnt_cyc  = cyc;
                mreq_cnt = 0;
            end
            if (mem_req) begin
                mreq_cnt++;
                if (exp_q.size() != 0) begin
                    mon_e = exp_q[0];
                    check("mem_addr", 64'(mem_addr), 64'(mon_e.addr));
                    check("mem_we", 64'(mem_we), 64'(mon_e.we));
                    check("mem_wdata", 64'(mem_wdata), 64'(mon_e.wdata));
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (err[i] && !rvalid[i]) check($sformatf("err_without_rvalid_r%0d", i), 64'd1, 64'd0);
                if (rvalid[i]) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("rvalid_unexpected_r%0d", i), 64'd1, 64'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("rvalid_id", 64'(i), 64'(mon_e.id));
                        check("rdata", 64'(rdata), 64'(mon_e.rdata));
                        check("err", 64'(err[i]), 64'(mon_e.err));
                        check("latency", 64'(cyc - gnt_cyc), 64'(mon_e.lat));
                        check("mem_req_cycles", 64'(mreq_cnt), 64'(mon_e.mreq));
                        check("mem_req_low_in_done", 64'(mem_req), 64'd0);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_state", 64'(state), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_rvalid", 64'({rvalid[0], rvalid[1], rvalid[2]}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: R1 read 0x100, ready in 2nd BUSY cycle -> rvalid 3 cycles after gnt, 0xDEADBEEF
        mem_lat = 2;
        rd_key  = 32'hDEADBFEF;
        exp_gnt_q.push_back(2'd1);
        exp_q.push_back(mk(2'd1, 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3, 2));
        issue(1, 1'b0, 32'h100, 32'h0, 1'b0);
        drain();

        // 2: all three at once -> R0, R1, R2; stray ready pulses outside BUSY
        mem_lat  = 1;
        rd_key   = 32'h0;
        stray_en = 1'b1;
        exp_gnt_q.push_back(2'd0);
        exp_gnt_q.push_back(2'd1);
        exp_gnt_q.push_back(2'd2);
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 32'h10, 32'h0,    32'h10, 2, 1));
        exp_q.push_back(mk(2'd1, 1'b0, 1'b1, 32'h20, 32'h1234, 32'h20, 2, 1));
        exp_q.push_back(mk(2'd2, 1'b0, 1'b0, 32'h30, 32'h0,    32'h30, 2, 1));
        fork
            issue(0, 1'b0, 32'h10, 32'h0, 1'b0);
            issue(1, 1'b1, 32'h20, 32'h1234, 1'b0);
            issue(2, 1'b0, 32'h30, 32'h0, 1'b0);
        join
        drain();

        // 3: R0 back-to-back, R1 held: grants at 0,3,6 to R0, R1 promoted at 9, then R0
        exp_gnt_q.push_back(2'd0);
        exp_gnt_q.push_back(2'd0);
        exp_gnt_q.push_back(2'd0);
        exp_gnt_q.push_back(2'd1);
        exp_gnt_q.push_back(2'd0);
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 32'h400, 32'h0, 32'h400, 2, 1));
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 32'h404, 32'h0, 32'h404, 2, 1));
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 32'h408, 32'h0, 32'h408, 2, 1));
        exp_q.push_back(mk(2'd1, 1'b0, 1'b0, 32'h500, 32'h0, 32'h500, 2, 1));
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 32'h40C, 32'h0, 32'h40C, 2, 1));
        fork
            begin
                issue(0, 1'b0, 32'h400, 32'h0, 1'b1);
                issue(0, 1'b0, 32'h404, 32'h0, 1'b1);
                issue(0, 1'b0, 32'h408, 32'h0, 1'b1);
                issue(0, 1'b0, 32'h40C, 32'h0, 1'b0);
            end
            issue(1, 1'b0, 32'h500, 32'h0, 1'b0);
        join
        drain();
        stray_en = 1'b0;

        // 4: R0 write 0x55AA to 0x40, ready in 3rd BUSY cycle; fields checked every BUSY cycle
        mem_lat = 3;
        exp_gnt_q.push_back(2'd0);
        exp_q.push_back(mk(2'd0, 1'b0, 1'b1, 32'h40, 32'h55AA, 32'h40, 4, 3));
        issue(0, 1'b1, 32'h40, 32'h55AA, 1'b0);
        drain();

        // 5: reset during BUSY drops the transaction; R2 then granted normally
        mem_lat = 0;
        exp_gnt_q.push_back(2'd0);
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 32'h80, 32'h0, 32'h80, 0, 0));
        issue(0, 1'b0, 32'h80, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check("busy_before_reset", 64'(busy), 64'd1);
        check("mem_req_before_reset", 64'(mem_req), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_mem_req", 64'(mem_req), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
        check("mid_rst_rvalid", 64'({rvalid[0], rvalid[1], rvalid[2]}), 64'd0);
        void'(exp_q.pop_front());
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        mem_lat = 2;
        @(posedge clk);
        #1;
        exp_gnt_q.push_back(2'd2);
        exp_q.push_back(mk(2'd2, 1'b0, 1'b0, 32'h90, 32'h0, 32'h90, 3, 2));
        issue(2, 1'b0, 32'h90, 32'h0, 1'b0);
        drain();

`ifdef MEM_TIMEOUT_EN
        // 6: memory never answers -> err after 4 BUSY cycles, rdata forced to 0
        mem_lat = 0;
        exp_gnt_q.push_back(2'd1);
        exp_q.push_back(mk(2'd1, 1'b1, 1'b0, 32'h200, 32'h0, 32'h0, 5, 4));
        issue(1, 1'b0, 32'h200, 32'h0, 1'b0);
        drain();
        check("timeout_back_idle", 64'(state), 64'd0);
`endif

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("exp_gnt_q_empty", 64'(exp_gnt_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
